// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// ----------------
// Fetch stage of the 16-bit accumulator processor. It holds the PC, reads
// instruction words from instruction memory over a req/ready handshake and
// latches them into the instruction register (IR).
//
// State table:
//   state | meaning
//   IDLE  | no memory request outstanding; Branch loads PC, Fetch starts a read
//   REQ   | MemReq high, MemAddr = PC held stable until MemRdy, Branch or timeout
//
// Ports:
//   CLK, RST_N        clock (rising edge), synchronous active-low reset
//   Fetch             control unit request to fetch the next instruction
//   Branch            load BranchTarget into PC (also aborts a fetch in flight)
//   BranchTarget      new PC value
//   MemReq, MemAddr   read request and address to instruction memory
//   MemRdy, MemData   memory data-valid strobe and instruction word
//   PC, IR            program counter and instruction register
//   Opcode            IR[15:12]
//   Addr12            IR[11:0]
//   Imm4              IR[3:0], drives the downstream zero extender directly
//   IRValid           one-cycle pulse after IR has been updated
//   Busy              high while not in IDLE
//   Fault             sticky fetch-timeout flag
//
// Build option: define FETCH_TIMEOUT_EN to add the fetch watchdog. Without it
// REQ waits indefinitely and Fault is tied low.

module instr_fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_INC   = 2,
    parameter int                 TIMEOUT  = 15
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Fetch,
    input  logic              Branch,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemRdy,
    input  logic [15:0]       MemData,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       IR,
    output logic [3:0]        Opcode,
    output logic [11:0]       Addr12,
    output logic [3:0]        Imm4,
    output logic              IRValid,
    output logic              Busy,
    output logic              Fault
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("instr_fetch_unit: TIMEOUT must be in 1..255");
    end

    logic [0:0] state;
    logic       fault_q;
    logic       timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    // Count of REQ cycles that have ended without MemRdy; timeout fires in
    // the cycle whose end would make the count equal TIMEOUT.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wd_cnt;

    assign timeout_hit = (state == REQ) && !MemRdy && (wd_cnt == WD_LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wd_cnt  <= 8'd0;
            fault_q <= 1'b0;
        end else if (state == IDLE) begin
            // Held at zero while idle so every REQ entry starts from zero.
            wd_cnt <= 8'd0;
        end else if (!Branch && !MemRdy) begin
            if (timeout_hit) begin
                fault_q <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fault_q     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            PC      <= RESET_PC;
            IR      <= 16'h0000;
            IRValid <= 1'b0;
        end else begin
            IRValid <= 1'b0;
            if (state == IDLE) begin
                // Branch wins over a simultaneous Fetch; the Fetch is dropped.
                if (Branch) begin
                    PC <= BranchTarget;
                end else if (Fetch && !fault_q) begin
                    state <= REQ;
                end
            end else begin
                if (Branch) begin
                    // Abort: the returning word (if any) is discarded.
                    PC    <= BranchTarget;
                    state <= IDLE;
                end else if (MemRdy) begin
                    IR      <= MemData;
                    PC      <= PC + ADDR_W'(PC_INC);
                    IRValid <= 1'b1;
                    state   <= IDLE;
                end else if (timeout_hit) begin
                    state <= IDLE;
                end
            end
        end
    end

    assign MemReq  = (state == REQ);
    assign Busy    = (state != IDLE);
    assign MemAddr = PC;
    assign Opcode  = IR[15:12];
    assign Addr12  = IR[11:0];
    assign Imm4    = IR[3:0];
    assign Fault   = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vectors with hand-computed literal
// checks, plus a transaction-level model compared against the DUT every cycle.

module tb_instr_fetch_unit;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        Fetch;
    logic        Branch;
    logic [15:0] BranchTarget;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemRdy;
    logic [15:0] MemData;
    logic [15:0] PC;
    logic [15:0] IR;
    logic [3:0]  Opcode;
    logic [11:0] Addr12;
    logic [3:0]  Imm4;
    logic        IRValid;
    logic        Busy;
    logic        Fault;

    int vectors     = 0;
    int miscompares = 0;

    instr_fetch_unit #(
        .ADDR_W  (16),
        .RESET_PC(16'h0000),
        .PC_INC  (2),
        .TIMEOUT (TO)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .Fetch       (Fetch),
        .Branch      (Branch),
        .BranchTarget(BranchTarget),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemRdy      (MemRdy),
        .MemData     (MemData),
        .PC          (PC),
        .IR          (IR),
        .Opcode      (Opcode),
        .Addr12      (Addr12),
        .Imm4        (Imm4),
        .IRValid     (IRValid),
        .Busy        (Busy),
        .Fault       (Fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a fetch is either outstanding or not; it tracks how many cycles
    // it has waited, and it ends by branch, by data, or by watchdog expiry.
    logic        m_pending = 1'b0;
    int          m_waited  = 0;
    logic [15:0] m_pc      = 16'h0000;
    logic [15:0] m_ir      = 16'h0000;
    logic        m_irv     = 1'b0;
    logic        m_fault   = 1'b0;
    logic        started   = 1'b0;

    always @(posedge CLK) begin
        started = 1'b1;
        if (!RST_N) begin
            m_pending = 1'b0;
            m_waited  = 0;
            m_pc      = 16'h0000;
            m_ir      = 16'h0000;
            m_irv     = 1'b0;
            m_fault   = 1'b0;
        end else begin
            m_irv = 1'b0;
            if (!m_pending) begin
                if (Branch)                 m_pc = BranchTarget;
                else if (Fetch && !m_fault) begin
                    m_pending = 1'b1;
                    m_waited  = 0;
                end
            end else if (Branch) begin
                m_pc      = BranchTarget;
                m_pending = 1'b0;
            end else if (MemRdy) begin
                m_ir      = MemData;
                m_pc      = 16'((32'(m_pc) + 2) % 65536);
                m_irv     = 1'b1;
                m_pending = 1'b0;
            end else begin
                m_waited++;
`ifdef FETCH_TIMEOUT_EN
                if (m_waited == TO) begin
                    m_fault   = 1'b1;
                    m_pending = 1'b0;
                end
`endif
            end
        end
    end

    always @(negedge CLK) begin
        if (started) begin
            chk("m_memreq",  32'(MemReq),  32'(m_pending));
            chk("m_busy",    32'(Busy),    32'(m_pending));
            chk("m_memaddr", 32'(MemAddr), 32'(m_pc));
            chk("m_pc",      32'(PC),      32'(m_pc));
            chk("m_ir",      32'(IR),      32'(m_ir));
            chk("m_opcode",  32'(Opcode),  32'(m_ir[15:12]));
            chk("m_addr12",  32'(Addr12),  32'(m_ir[11:0]));
            chk("m_imm4",    32'(Imm4),    32'(m_ir[3:0]));
            chk("m_irvalid", 32'(IRValid), 32'(m_irv));
            chk("m_fault",   32'(Fault),   32'(m_fault));
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0; Fetch = 1'b0; Branch = 1'b0; BranchTarget = 16'h0000;
        MemRdy = 1'b0; MemData = 16'h0000;
        step(); step();
        RST_N = 1'b1;
        chk("rst_pc", 32'(PC), 32'h0000);
        chk("rst_ir", 32'(IR), 32'h0000);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_fault", 32'(Fault), 32'h0);

        // Single fetch, data ready in the first REQ cycle.
        Fetch = 1'b1;
        step();
        Fetch = 1'b0; MemRdy = 1'b1; MemData = 16'hA5C3;
        chk("t1_memreq", 32'(MemReq), 32'h1);
        chk("t1_memaddr", 32'(MemAddr), 32'h0000);
        step();
        MemRdy = 1'b0;
        chk("t1_ir", 32'(IR), 32'hA5C3);
        chk("t1_opcode", 32'(Opcode), 32'hA);
        chk("t1_addr12", 32'(Addr12), 32'h5C3);
        chk("t1_imm4", 32'(Imm4), 32'h3);
        chk("t1_pc", 32'(PC), 32'h0002);
        chk("t1_irvalid", 32'(IRValid), 32'h1);
        step();
        chk("t1_irvalid_off", 32'(IRValid), 32'h0);

        // MemRdy delayed three cycles; Fetch held high while busy is ignored.
        Fetch = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t2_memreq", 32'(MemReq), 32'h1);
            chk("t2_memaddr", 32'(MemAddr), 32'h0002);
            if (i == 1) Fetch = 1'b0;
            if (i == 3) begin MemRdy = 1'b1; MemData = 16'h1234; end
            step();
        end
        MemRdy = 1'b0;
        chk("t2_ir", 32'(IR), 32'h1234);
        chk("t2_pc", 32'(PC), 32'h0004);
        chk("t2_busy", 32'(Busy), 32'h0);

        // Branch aborts a fetch even when MemRdy arrives the same cycle.
        Fetch = 1'b1;
        step();
        Fetch = 1'b0; Branch = 1'b1; BranchTarget = 16'h00F0;
        MemRdy = 1'b1; MemData = 16'hFFFF;
        step();
        Branch = 1'b0; MemRdy = 1'b0;
        chk("t3_ir", 32'(IR), 32'h1234);
        chk("t3_irvalid", 32'(IRValid), 32'h0);
        chk("t3_pc", 32'(PC), 32'h00F0);
        chk("t3_busy", 32'(Busy), 32'h0);
        // Branch together with Fetch in IDLE: PC loads, Fetch is dropped.
        Branch = 1'b1; Fetch = 1'b1; BranchTarget = 16'h0100;
        step();
        Branch = 1'b0; Fetch = 1'b0;
        chk("t3_bf_memreq", 32'(MemReq), 32'h0);
        chk("t3_bf_pc", 32'(PC), 32'h0100);
        step();
        chk("t3_bf_memreq2", 32'(MemReq), 32'h0);

        // PC wrap from FFFE.
        Branch = 1'b1; BranchTarget = 16'hFFFE;
        step();
        Branch = 1'b0; Fetch = 1'b1;
        step();
        Fetch = 1'b0; MemRdy = 1'b1; MemData = 16'h0007;
        chk("t4_memaddr", 32'(MemAddr), 32'hFFFE);
        step();
        MemRdy = 1'b0;
        chk("t4_pc", 32'(PC), 32'h0000);
        chk("t4_imm4", 32'(Imm4), 32'h7);
        chk("t4_opcode", 32'(Opcode), 32'h0);

        // Reset mid-fetch with MemRdy in the reset cycle.
        Branch = 1'b1; BranchTarget = 16'h0040;
        step();
        Branch = 1'b0; Fetch = 1'b1;
        step();
        Fetch = 1'b0; RST_N = 1'b0; MemRdy = 1'b1; MemData = 16'hBEEF;
        step();
        RST_N = 1'b1; MemRdy = 1'b0;
        chk("t5_pc", 32'(PC), 32'h0000);
        chk("t5_ir", 32'(IR), 32'h0000);
        chk("t5_memreq", 32'(MemReq), 32'h0);
        chk("t5_irvalid", 32'(IRValid), 32'h0);

        // MemRdy in IDLE is ignored.
        MemRdy = 1'b1; MemData = 16'h9999;
        step();
        MemRdy = 1'b0;
        chk("t5_idle_ir", 32'(IR), 32'h0000);
        chk("t5_idle_irvalid", 32'(IRValid), 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // Watchdog: four REQ cycles without MemRdy raise Fault.
        Fetch = 1'b1;
        step();
        Fetch = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("t6_memreq", 32'(MemReq), 32'h1);
            chk("t6_fault_low", 32'(Fault), 32'h0);
            step();
        end
        chk("t6_fault", 32'(Fault), 32'h1);
        chk("t6_memreq_off", 32'(MemReq), 32'h0);
        chk("t6_pc", 32'(PC), 32'h0000);
        Fetch = 1'b1;
        step();
        Fetch = 1'b0;
        chk("t6_fetch_ignored", 32'(MemReq), 32'h0);
        Branch = 1'b1; BranchTarget = 16'h0010;
        step();
        Branch = 1'b0;
        chk("t6_branch_pc", 32'(PC), 32'h0010);
        chk("t6_fault_sticky", 32'(Fault), 32'h1);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        chk("t6_fault_cleared", 32'(Fault), 32'h0);
`else
        // No watchdog: REQ waits indefinitely until Branch aborts it.
        Fetch = 1'b1;
        step();
        Fetch = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk("t6_wait_memreq", 32'(MemReq), 32'h1);
            step();
        end
        Branch = 1'b1; BranchTarget = 16'h0010;
        step();
        Branch = 1'b0;
        chk("t6_abort_busy", 32'(Busy), 32'h0);
        chk("t6_abort_pc", 32'(PC), 32'h0010);
        chk("t6_fault_zero", 32'(Fault), 32'h0);
`endif

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
